// File: rtl/cpm_word_packer.sv
// rtl/cpm_word_packer.sv - packs narrow samples LSB-first into FIFO words with full-flag backpressure
module cpm_word_packer #(
   parameter int DATA_WIDTH = 64,
   parameter int IN_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  Reset,
   input  logic                  in_valid,
   input  logic [IN_WIDTH-1:0]   in_data,
   input  logic                  in_last,
   output logic                  in_ready,
   input  logic                  fifo_full,
   output logic                  fifo_push,
   output logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  frame_done,
   output logic [15:0]           word_count
);

   localparam int LANES  = DATA_WIDTH / IN_WIDTH;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

   logic [DATA_WIDTH-1:0] asm_q;
   logic [LANE_W-1:0]     lane_q;
   logic [DATA_WIDTH-1:0] out_word_q;
   logic                  out_vld_q;
   logic                  out_last_q;

   logic                  accept;
   logic                  complete;
   logic                  push;
   logic                  lane_full;
   logic [DATA_WIDTH-1:0] merged;

   assign push      = out_vld_q && !fifo_full;
   assign in_ready  = !out_vld_q || !fifo_full;
   assign accept    = in_valid && in_ready;
   assign lane_full = (lane_q == LANE_W'(LANES - 1));
   assign complete  = accept && (lane_full || in_last);

   assign fifo_push = push;
   assign fifo_data = out_word_q;

   // Current partial word with the incoming sample dropped into its lane; higher lanes are still zero.
   always_comb begin
      merged = asm_q;
      for (int i = 0; i < LANES; i++) begin
         if (lane_q == LANE_W'(i)) begin
            merged[i*IN_WIDTH +: IN_WIDTH] = in_data;
         end
      end
   end

   // Assembly, output staging, push counting and frame-done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         asm_q      <= '0;
         lane_q     <= '0;
         out_word_q <= '0;
         out_vld_q  <= 1'b0;
         out_last_q <= 1'b0;
         frame_done <= 1'b0;
         word_count <= '0;
      end else if (Reset) begin
         asm_q      <= '0;
         lane_q     <= '0;
         out_word_q <= '0;
         out_vld_q  <= 1'b0;
         out_last_q <= 1'b0;
         frame_done <= 1'b0;
         word_count <= '0;
      end else begin
         if (complete) begin
            out_word_q <= merged;
            out_vld_q  <= 1'b1;
            out_last_q <= in_last;
            asm_q      <= '0;
            lane_q     <= '0;
         end else begin
            if (accept) begin
               asm_q  <= merged;
               lane_q <= lane_q + 1'b1;
            end
            if (push) begin
               out_vld_q <= 1'b0;
            end
         end
         frame_done <= push && out_last_q;
         if (push) begin
            word_count <= word_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_cpm_word_packer.sv
// tb/tb_cpm_word_packer.sv - self-checking bench for cpm_word_packer
module tb_cpm_word_packer;

   localparam int DW = 64;
   localparam int IW = 16;
   localparam int NL = DW / IW;

   logic          clk;
   logic          rst_n;
   logic          Reset;
   logic          in_valid;
   logic [IW-1:0] in_data;
   logic          in_last;
   logic          in_ready;
   logic          fifo_full;
   logic          fifo_push;
   logic [DW-1:0] fifo_data;
   logic          frame_done;
   logic [15:0]   word_count;

   cpm_word_packer #(.DATA_WIDTH(DW), .IN_WIDTH(IW)) dut (
      .clk(clk), .rst_n(rst_n), .Reset(Reset),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .fifo_full(fifo_full), .fifo_push(fifo_push), .fifo_data(fifo_data),
      .frame_done(frame_done), .word_count(word_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: samples of the current word kept as a list, finished word as a pending slot.
   logic [IW-1:0] m_samples[$];
   bit            m_pend;
   logic [DW-1:0] m_pend_word;
   bit            m_pend_last;
   logic [15:0]   m_count;
   bit            m_fd;
   bit            acc_flag;
   logic [DW-1:0] pushed[$];

   function automatic logic [DW-1:0] build_word(input logic [IW-1:0] s[$]);
      logic [DW-1:0] w = '0;
      foreach (s[i]) w = w | (DW'(s[i]) << (i * IW));
      return w;
   endfunction

   function automatic logic [DW-1:0] pushed_at(input int idx);
      if (idx < pushed.size()) return pushed[idx];
      return '0;
   endfunction

   task automatic model_clear();
      m_samples.delete();
      m_pend      = 0;
      m_pend_word = '0;
      m_pend_last = 0;
      m_count     = '0;
      m_fd        = 0;
      acc_flag    = 0;
   endtask

   initial model_clear();

   // Compare process: check outputs against the model, then advance the model by one clock.
   always @(negedge clk) begin
      bit exp_ready, exp_push;
      if (!rst_n) model_clear();
      exp_ready = !m_pend || !fifo_full;
      exp_push  = m_pend && !fifo_full;
      chk("m_in_ready", in_ready, exp_ready);
      chk("m_fifo_push", fifo_push, exp_push);
      chk("m_frame_done", frame_done, m_fd);
      chk("m_word_count", word_count, m_count);
      if (m_pend) chk("m_fifo_data", fifo_data, m_pend_word);
      if (fifo_push) pushed.push_back(fifo_data);
      if (rst_n) begin
         if (Reset) begin
            model_clear();
         end else begin
            acc_flag = in_valid && exp_ready;
            m_fd     = exp_push && m_pend_last;
            if (exp_push) begin
               m_count = m_count + 16'd1;
               m_pend  = 0;
            end
            if (acc_flag) begin
               m_samples.push_back(in_data);
               if (m_samples.size() == NL || in_last) begin
                  m_pend      = 1;
                  m_pend_word = build_word(m_samples);
                  m_pend_last = in_last;
                  m_samples.delete();
               end
            end
         end
      end
   end

   int stall_cnt;

   task automatic send(input logic [IW-1:0] d, input bit last);
      bit done = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      for (int k = 0; k < 100 && !done; k++) begin
         @(posedge clk);
         if (acc_flag) done = 1;
         else stall_cnt++;
      end
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!done) chk("send_timeout", 1'b0, 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      Reset = 1'b1;
      @(posedge clk);
      #1;
      Reset = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; Reset = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; fifo_full = 1'b0;
      @(negedge clk);
      chk("rst_push", fifo_push, 1'b0);
      chk("rst_data", fifo_data, '0);
      chk("rst_ready", in_ready, 1'b1);
      chk("rst_count", word_count, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);

      // Basic pack
      send(16'h1111, 0); send(16'h2222, 0); send(16'h3333, 0); send(16'h4444, 0);
      @(negedge clk);
      chk("basic_push", fifo_push, 1'b1);
      chk("basic_data", fifo_data, 64'h4444_3333_2222_1111);
      @(negedge clk);
      chk("basic_count", word_count, 16'd1);
      @(posedge clk); #1;

      // Partial frame
      send(16'hAAAA, 0); send(16'hBBBB, 1);
      @(negedge clk);
      chk("part_push", fifo_push, 1'b1);
      chk("part_data", fifo_data, 64'h0000_0000_BBBB_AAAA);
      @(negedge clk);
      chk("part_fd_hi", frame_done, 1'b1);
      @(negedge clk);
      chk("part_fd_lo", frame_done, 1'b0);
      @(posedge clk); #1;

      // Single-sample frame
      send(16'hCCCC, 1);
      @(negedge clk);
      chk("single_data", fifo_data, 64'h0000_0000_0000_CCCC);
      @(posedge clk); #1;

      // Backpressure
      fifo_full = 1'b1;
      send(16'h0A01, 0); send(16'h0A02, 0); send(16'h0A03, 0); send(16'h0A04, 0);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("bp_push", fifo_push, 1'b0);
         chk("bp_ready", in_ready, 1'b0);
         chk("bp_data", fifo_data, 64'h0A04_0A03_0A02_0A01);
      end
      @(posedge clk); #1;
      fifo_full = 1'b0;
      @(negedge clk);
      chk("bp_release_push", fifo_push, 1'b1);
      chk("bp_release_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      idle(2);

      // Streaming
      pulse_reset();
      pushed.delete();
      stall_cnt = 0;
      for (int i = 0; i < 64; i++) send(IW'(16'h0100 + i), 0);
      idle(3);
      chk("stream_pushes", 64'(pushed.size()), 64'd16);
      chk("stream_count", word_count, 16'd16);
      chk("stream_stalls", 64'(stall_cnt), 64'd0);
      chk("stream_first", pushed_at(0), 64'h0103_0102_0101_0100);
      chk("stream_last", pushed_at(15), 64'h013F_013E_013D_013C);

      // Reset mid-word
      pulse_reset();
      pushed.delete();
      send(16'h1234, 0); send(16'h4321, 0);
      pulse_reset();
      send(16'h5555, 0); send(16'h6666, 0); send(16'h7777, 0); send(16'h8888, 0);
      idle(3);
      chk("rmid_pushes", 64'(pushed.size()), 64'd1);
      chk("rmid_data", pushed_at(0), 64'h8888_7777_6666_5555);
      chk("rmid_count", word_count, 16'd1);

      // Asynchronous reset mid-cycle with a word held by backpressure
      fifo_full = 1'b1;
      send(16'h0B01, 0); send(16'h0B02, 0); send(16'h0B03, 0); send(16'h0B04, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_push", fifo_push, 1'b0);
      chk("arst_data", fifo_data, '0);
      chk("arst_fd", frame_done, 1'b0);
      chk("arst_count", word_count, '0);
      chk("arst_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      fifo_full = 1'b0;
      idle(2);

      // Wrap of the pushed-word counter
      pulse_reset();
      for (int i = 0; i < 65535; i++) send(IW'(i), 1);
      idle(3);
      chk("wrap_max", word_count, 16'hFFFF);
      send(16'hFEED, 1);
      idle(3);
      chk("wrap_zero", word_count, 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/cpm_word_packer.md
# cpm_word_packer

Upstream feeder for the CPM 64-bit FIFO: accepts narrow EEG samples over a valid/ready handshake, packs them LSB-first into DATA_WIDTH words, and drives the FIFO push/data_in pair using the FIFO's `full` flag for backpressure. A frame-end marker forces emission of a partial word, with the unused upper lanes zero-padded. The block also keeps a pushed-word counter and raises a frame-done pulse for the CPM controller.

## Interface
- DATA_WIDTH, 64: packed word width; must match the FIFO DATA_WIDTH.
- IN_WIDTH, 16: sample width; DATA_WIDTH must be an integer multiple of IN_WIDTH.
- LANES, DATA_WIDTH/IN_WIDTH: samples per word (4 at defaults); derived, not overridden.
- clk  input  1  single clock.
- rst_n  input  1  asynchronous active-low reset.
- Reset  input  1  synchronous clear; same cycle as the FIFO Reset; priority over all other inputs.
- in_valid  input  1  sample valid.
- in_data  input  IN_WIDTH  sample.
- in_last  input  1  sample is the last of a frame; qualified by in_valid.
- in_ready  output  1  sample accepted when in_valid && in_ready.
- fifo_full  input  1  FIFO full flag.
- fifo_push  output  1  push strobe to the FIFO.
- fifo_data  output  DATA_WIDTH  word to FIFO data_in.
- frame_done  output  1  one-cycle pulse after the last word of a frame is pushed.
- word_count  output  16  words pushed since reset or Reset; wraps.

## Operation
- State: assembly register `asm` (DATA_WIDTH), lane counter `lane` (0..LANES-1), output register `out_word`, output-valid flag `out_vld`, and `out_last` tag.
- Reset values (rst_n low or Reset high at an edge) are all 0: asm, lane, out_word, out_vld, out_last, frame_done, word_count. After reset, fifo_push=0, fifo_data=0 and in_ready=1.
- in_ready = !out_vld || !fifo_full. This is combinational; backpressure stalls input only while a finished word cannot drain.
- fifo_push = out_vld && !fifo_full. fifo_data = out_word. The block never pushes into a full FIFO.
- On accept with lane < LANES-1 and in_last = 0:
  - asm[lane*IN_WIDTH +: IN_WIDTH] <= in_data
  - lane <= lane+1
- On accept with lane == LANES-1 or in_last = 1 (word completion):
  - out_word <= asm with in_data inserted at the current lane; lanes above it are 0.
  - out_vld <= 1; out_last <= in_last.
  - asm <= 0; lane <= 0.
- On a push cycle with no word completion: out_vld <= 0.
- Push and completion in the same cycle: out_word is overwritten, out_vld stays 1. This allows back-to-back words at full rate.
- word_count increments by 1 on every push cycle, modulo 2^16.
- frame_done <= fifo_push && out_last. This gives a registered pulse in the cycle after the push. It is never asserted otherwise.
- in_last on lane 0 emits a single-sample word with the upper LANES-1 lanes zero.
- A frame with no in_last keeps packing across words indefinitely.
- Reset mid-word discards the partial asm and any pending out_word; no push occurs in the cycle after Reset.

## Timing
- A completing sample accepted at edge T gives out_vld=1 during cycle T+1. fifo_push is high in T+1 if fifo_full=0, and the word is written to the FIFO at edge T+2.
- Sample-to-push latency is 1 cycle. Throughput is 1 sample/cycle, i.e. one word per LANES cycles, with no bubbles while the FIFO is not full.
- fifo_full high with out_vld=1: fifo_push=0, in_ready=0, and out_word is held stable until the first cycle with fifo_full=0.
- The FIFO full flag is derived from its registered count, so there is no combinational loop through fifo_push.
- frame_done is high exactly one cycle, at T+2 for a last word pushed in T+1.

## Test plan
- Basic pack: samples 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles.
  - Expect one push with fifo_data = 0x4444_3333_2222_1111, one cycle after the 0x4444 accept.
  - Expect word_count = 1.
- Partial frame: 0xAAAA, 0xBBBB with in_last on 0xBBBB.
  - Expect fifo_data = 0x0000_0000_BBBB_AAAA.
  - Expect frame_done high for one cycle, the cycle after the push.
- Backpressure: hold fifo_full=1 while a word completes.
  - Expect fifo_push=0, in_ready=0, and fifo_data stable for 10 cycles.
  - After fifo_full drops: exactly one push, then in_ready=1 in the same cycle.
- Streaming: 64 consecutive samples with fifo_full=0.
  - Expect 16 pushes with no gaps in the input.
  - Expect word_count = 16 and the data order preserved.
- Reset mid-word: 2 samples, then Reset for 1 cycle, then 0x5555, 0x6666, 0x7777, 0x8888.
  - Expect a single word 0x8888_7777_6666_5555 and word_count = 1.
  - Also drive rst_n low asynchronously mid-cycle: all outputs must go to 0 immediately.
- Wrap: preload 65535 pushes (or force word_count), then one more word; expect word_count = 0.
